// File: rtl/mftx_pkg.sv
// mftx_pkg: shared definitions for the matrix frame transmitter.
//   - mftx_state_e : frame FSM states (IDLE, LEAD, DATA, TAIL, GAP)
//   - idx_width()  : index width for an N-entry structure (minimum 1 bit)
//   - LFSR polynomial helper and seeds for the optional LFSR fill
//     (MFTX_LFSR_FILL_EN)
//   - MFTX_BIT_NUM : sample width shared with the bidiagonalization core
package mftx_pkg;

    localparam int unsigned MFTX_BIT_NUM = 18;

    localparam int unsigned MFTX_LFSR_W  = 18;
    localparam logic [MFTX_LFSR_W-1:0] MFTX_LFSR_SEED_RE = 18'h00001;
    localparam logic [MFTX_LFSR_W-1:0] MFTX_LFSR_SEED_IM = 18'h2AAAA;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_DATA,
        ST_TAIL,
        ST_GAP
    } mftx_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Fibonacci step for x^18 + x^11 + 1: feedback from stages 18 and 11.
    function automatic logic [MFTX_LFSR_W-1:0] lfsr_step(input logic [MFTX_LFSR_W-1:0] s);
        return {s[MFTX_LFSR_W-2:0], s[17] ^ s[10]};
    endfunction

endpackage

// File: rtl/matrix_frame_tx_if.sv
// matrix_frame_tx_if: host-side bus of the matrix frame transmitter.
//   Host -> transmitter : wr_en, wr_addr, wr_re, wr_im, start
//                         (+ lfsr_mode when MFTX_LFSR_FILL_EN is defined)
//   Transmitter -> host : tx_valid, tx_re, tx_im, busy, done, wr_err
// Modports: master = host/test side, slave = matrix_frame_tx.
interface matrix_frame_tx_if #(
    parameter int unsigned BIT_NUM = 18,
    parameter int unsigned ADDR_W  = 4
);
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic signed [BIT_NUM-1:0] wr_re;
    logic signed [BIT_NUM-1:0] wr_im;
    logic                      start;
`ifdef MFTX_LFSR_FILL_EN
    logic                      lfsr_mode;
`endif
    logic                      tx_valid;
    logic signed [BIT_NUM-1:0] tx_re;
    logic signed [BIT_NUM-1:0] tx_im;
    logic                      busy;
    logic                      done;
    logic                      wr_err;

`ifdef MFTX_LFSR_FILL_EN
    modport master (
        output wr_en, wr_addr, wr_re, wr_im, start, lfsr_mode,
        input  tx_valid, tx_re, tx_im, busy, done, wr_err
    );
    modport slave (
        input  wr_en, wr_addr, wr_re, wr_im, start, lfsr_mode,
        output tx_valid, tx_re, tx_im, busy, done, wr_err
    );
`else
    modport master (
        output wr_en, wr_addr, wr_re, wr_im, start,
        input  tx_valid, tx_re, tx_im, busy, done, wr_err
    );
    modport slave (
        input  wr_en, wr_addr, wr_re, wr_im, start,
        output tx_valid, tx_re, tx_im, busy, done, wr_err
    );
`endif
endinterface

// File: rtl/mftx_buffer.sv
// mftx_buffer: DEPTH-entry complex register file, one synchronous write
// port and one combinational read port. Cleared by rst_n.
//   clk, rst_n            : clock, async active-low reset
//   i_wr_en/i_wr_addr     : write strobe and element index
//   i_wr_re/i_wr_im       : sample to store
//   i_rd_addr             : read index
//   o_rd_re/o_rd_im       : stored sample at i_rd_addr
module mftx_buffer #(
    parameter int unsigned BIT_NUM = 18,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ADDR_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_wr_en,
    input  logic [ADDR_W-1:0]         i_wr_addr,
    input  logic signed [BIT_NUM-1:0] i_wr_re,
    input  logic signed [BIT_NUM-1:0] i_wr_im,
    input  logic [ADDR_W-1:0]         i_rd_addr,
    output logic signed [BIT_NUM-1:0] o_rd_re,
    output logic signed [BIT_NUM-1:0] o_rd_im
);
    logic signed [BIT_NUM-1:0] r_re [DEPTH];
    logic signed [BIT_NUM-1:0] r_im [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_re[i] <= '0;
                r_im[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_re[i_wr_addr] <= i_wr_re;
            r_im[i_wr_addr] <= i_wr_im;
        end
    end

    assign o_rd_re = r_re[i_rd_addr];
    assign o_rd_im = r_im[i_rd_addr];

endmodule

// File: rtl/matrix_frame_tx.sv
// matrix_frame_tx: holds a ROWS x COLS complex matrix and, on start, sends
// it row-major on a valid/R/I stream framed for the bidiagonalization core:
// LEAD (valid, entry 0), DATA (N entries), TAIL (invalid, entry 0), then
// GAP_CYCLES idle cycles before re-arming.
//   clk, rst_n : clock, async active-low reset
//   bus.slave  : wr_en/wr_addr/wr_re/wr_im (buffer write, IDLE only),
//                start, tx_valid/tx_re/tx_im (stream), busy, done, wr_err
// Optional: define MFTX_LFSR_FILL_EN to add bus.lfsr_mode, selecting two
// 18-bit LFSRs as the sample source instead of the buffer.
module matrix_frame_tx
    import mftx_pkg::*;
#(
    parameter int unsigned BIT_NUM    = MFTX_BIT_NUM,
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLS       = 4,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    matrix_frame_tx_if.slave bus
);
    localparam int unsigned N  = ROWS * COLS;
    localparam int unsigned AW = idx_width(N);
    localparam int unsigned GW = idx_width((GAP_CYCLES < 2) ? 2 : GAP_CYCLES);

    mftx_state_e r_state, w_next;
    logic [AW-1:0] r_cnt, w_cnt_next;
    logic [GW-1:0] r_gap, w_gap_next;
    logic [AW-1:0] w_rd_idx;
    logic          w_valid, w_use_sample, w_done;
    logic          w_wr_ok;

    logic signed [BIT_NUM-1:0] w_buf_re, w_buf_im;
    logic signed [BIT_NUM-1:0] w_byp_re, w_byp_im;
    logic signed [BIT_NUM-1:0] w_src_re, w_src_im;

    logic                      r_tx_valid, r_busy, r_done, r_wr_err;
    logic signed [BIT_NUM-1:0] r_tx_re, r_tx_im;

    assign w_wr_ok = bus.wr_en && (r_state == ST_IDLE);

    mftx_buffer #(
        .BIT_NUM (BIT_NUM),
        .DEPTH   (N),
        .ADDR_W  (AW)
    ) u_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_ok),
        .i_wr_addr (bus.wr_addr),
        .i_wr_re   (bus.wr_re),
        .i_wr_im   (bus.wr_im),
        .i_rd_addr (w_rd_idx),
        .o_rd_re   (w_buf_re),
        .o_rd_im   (w_buf_im)
    );

    // Outputs are registered from the next-state view, so the LEAD sample is
    // read in the start cycle itself; forward a same-cycle write so the frame
    // carries the new value.
    always_comb begin
        w_byp_re = w_buf_re;
        w_byp_im = w_buf_im;
        if (w_wr_ok && (bus.wr_addr == w_rd_idx)) begin
            w_byp_re = bus.wr_re;
            w_byp_im = bus.wr_im;
        end
    end

`ifdef MFTX_LFSR_FILL_EN
    logic [MFTX_LFSR_W-1:0] r_lfsr_re, r_lfsr_im;
    logic [MFTX_LFSR_W-1:0] r_lfsr0_re, r_lfsr0_im;
    logic                   r_mode, w_mode;
    logic [MFTX_LFSR_W-1:0] w_pick_re, w_pick_im;

    function automatic logic signed [BIT_NUM-1:0] to_bn(input logic [MFTX_LFSR_W-1:0] v);
        return BIT_NUM'($signed(v));
    endfunction

    // Mode is taken live in the start cycle, then held for the frame.
    assign w_mode = (r_state == ST_IDLE) ? bus.lfsr_mode : r_mode;

    always_comb begin
        w_pick_re = r_lfsr_re;
        w_pick_im = r_lfsr_im;
        if (w_next == ST_TAIL) begin
            w_pick_re = r_lfsr0_re;
            w_pick_im = r_lfsr0_im;
        end
        w_src_re = w_mode ? to_bn(w_pick_re) : w_byp_re;
        w_src_im = w_mode ? to_bn(w_pick_im) : w_byp_im;
    end

    // Each DATA output consumes the current LFSR value and advances it, so
    // the value at frame start is element 0; it is saved for the TAIL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr_re  <= MFTX_LFSR_SEED_RE;
            r_lfsr_im  <= MFTX_LFSR_SEED_IM;
            r_lfsr0_re <= MFTX_LFSR_SEED_RE;
            r_lfsr0_im <= MFTX_LFSR_SEED_IM;
            r_mode     <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && bus.start) begin
                r_mode     <= bus.lfsr_mode;
                r_lfsr0_re <= r_lfsr_re;
                r_lfsr0_im <= r_lfsr_im;
            end
            if (w_next == ST_DATA) begin
                r_lfsr_re <= lfsr_step(r_lfsr_re);
                r_lfsr_im <= lfsr_step(r_lfsr_im);
            end
        end
    end
`else
    always_comb begin
        w_src_re = w_byp_re;
        w_src_im = w_byp_im;
    end
`endif

    always_comb begin
        w_next       = r_state;
        w_cnt_next   = r_cnt;
        w_gap_next   = r_gap;
        w_rd_idx     = '0;
        w_valid      = 1'b0;
        w_use_sample = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next       = ST_LEAD;
                    w_valid      = 1'b1;
                    w_use_sample = 1'b1;
                    w_cnt_next   = '0;
                end
            end
            ST_LEAD: begin
                w_next       = ST_DATA;
                w_valid      = 1'b1;
                w_use_sample = 1'b1;
                w_cnt_next   = '0;
            end
            ST_DATA: begin
                w_use_sample = 1'b1;
                if (r_cnt == AW'(N - 1)) begin
                    // TAIL repeats entry 0 with valid low.
                    w_next = ST_TAIL;
                end else begin
                    w_cnt_next = r_cnt + AW'(1);
                    w_rd_idx   = r_cnt + AW'(1);
                    w_valid    = 1'b1;
                end
            end
            ST_TAIL: begin
                w_gap_next = '0;
                if (GAP_CYCLES == 0) begin
                    w_next = ST_IDLE;
                    w_done = 1'b1;
                end else begin
                    w_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap == GW'(GAP_CYCLES - 1)) begin
                    w_next = ST_IDLE;
                    w_done = 1'b1;
                end else begin
                    w_gap_next = r_gap + GW'(1);
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_gap      <= '0;
            r_tx_valid <= 1'b0;
            r_tx_re    <= '0;
            r_tx_im    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_wr_err   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_cnt      <= w_cnt_next;
            r_gap      <= w_gap_next;
            r_tx_valid <= w_valid;
            r_tx_re    <= w_use_sample ? w_src_re : '0;
            r_tx_im    <= w_use_sample ? w_src_im : '0;
            r_busy     <= (w_next != ST_IDLE);
            r_done     <= w_done;
            r_wr_err   <= bus.wr_en && (r_state != ST_IDLE);
        end
    end

    assign bus.tx_valid = r_tx_valid;
    assign bus.tx_re    = r_tx_re;
    assign bus.tx_im    = r_tx_im;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.wr_err   = r_wr_err;

endmodule
